// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - fixed-point constants, scheduler state type and phase wrap helper
package dsp_pkg;

    localparam logic [15:0]        PI_FIX      = 16'h6488;
    localparam logic signed [16:0] TWO_PI_FIX  = 17'sd51472;
    localparam logic [15:0]        PHASE_RESET = 16'hE000;

    typedef logic signed [15:0] fix16_13_t;
    typedef logic signed [15:0] fix16_14_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    // Advance a phase by an unsigned increment, keeping it inside [-pi, pi].
    // Increments beyond pi are clamped so one subtraction of 2*pi always suffices.
    function automatic fix16_13_t wrapPhase(input fix16_13_t acc, input logic [15:0] inc);
        logic [15:0]        incClamped;
        logic signed [16:0] sum;
        incClamped = (inc > PI_FIX) ? PI_FIX : inc;
        sum = $signed({acc[15], acc}) + $signed({1'b0, incClamped});
        if (sum > $signed({1'b0, PI_FIX})) begin
            sum = sum - TWO_PI_FIX;
        end
        return sum[15:0];
    endfunction

endpackage

// File: rtl/voice_tag_fifo.sv
// rtl/voice_tag_fifo.sv - small tag queue pairing core results with the voice that issued them
module voice_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          sysClk,
    input  logic          nReset,
    input  logic          push,
    input  logic [W-1:0]  pushData,
    input  logic          pop,
    output logic [W-1:0]  popData,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdPtr;
    logic [W-1:0] wrPtr;
    logic         doPush;
    logic         doPop;

    function automatic logic [W-1:0] bump(input logic [W-1:0] p);
        return (p == W'(DEPTH - 1)) ? '0 : p + W'(1);
    endfunction

    assign empty   = (count == '0);
    assign doPop   = pop && !empty;
    assign doPush  = push && (count != CW'(DEPTH));
    assign popData = mem[rdPtr];

    // Storage and circular pointers; a pop on an empty queue is ignored.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= bump(wrPtr);
            end
            if (doPop) begin
                rdPtr <= bump(rdPtr);
            end
        end
    end

    // Occupancy, which doubles as the outstanding-result count.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (doPush && !doPop) begin
            count <= count + CW'(1);
        end else if (doPop && !doPush) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/cordic_voice_scheduler.sv
// rtl/cordic_voice_scheduler.sv - shares one pipelined sin/cos core among oscillator voices
module cordic_voice_scheduler
    import dsp_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16
) (
    input  logic                          sysClk,
    input  logic                          nReset,
    input  logic                          audioClk,
    input  logic [NUM_VOICES*PHASE_W-1:0] phase_inc,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic                          clear_flags,
    output logic                          cordic_tvalid,
    output logic [PHASE_W-1:0]            cordic_tdata,
    input  logic                          cordic_rvalid,
    input  logic [31:0]                   cordic_rdata,
    output logic [NUM_VOICES*PHASE_W-1:0] voice_sin,
    output logic                          sample_valid,
    output logic                          overrun,
    output logic                          protocol_err
);

    localparam int TAG_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    logic             audioSync1;
    logic             audioSync2;
    logic             audioSync3;
    logic             strobe;
    sched_state_t     state;
    sched_state_t     nextState;
    logic [TAG_W-1:0] voiceIdx;
    logic             lastVoice;
    logic             issueNow;
    logic [15:0]      incShadow [NUM_VOICES];
    logic [NUM_VOICES-1:0] enShadow;
    fix16_13_t        phaseAcc [NUM_VOICES];
    fix16_14_t        sampleShadow [NUM_VOICES];
    fix16_13_t        nextPhase;
    logic [TAG_W-1:0] tagOut;
    logic             tagEmpty;
    logic [CNT_W-1:0] tagCount;
    logic             unusedCos;

    // The core's cosine half is not needed by the mixer.
    assign unusedCos = ^cordic_rdata[31:16];

    assign strobe    = audioSync2 && !audioSync3;
    assign lastVoice = (voiceIdx == TAG_W'(NUM_VOICES - 1));
    assign issueNow  = (state == S_ISSUE) && enShadow[voiceIdx];
    assign nextPhase = wrapPhase(phaseAcc[voiceIdx], incShadow[voiceIdx]);

    voice_tag_fifo #(
        .DEPTH (NUM_VOICES),
        .W     (TAG_W),
        .CW    (CNT_W)
    ) tagFifo (
        .sysClk   (sysClk),
        .nReset   (nReset),
        .push     (issueNow),
        .pushData (voiceIdx),
        .pop      (cordic_rvalid),
        .popData  (tagOut),
        .empty    (tagEmpty),
        .count    (tagCount)
    );

    // Two-flop synchroniser for the audio strobe plus one flop for rising-edge detect.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            audioSync1 <= 1'b0;
            audioSync2 <= 1'b0;
            audioSync3 <= 1'b0;
        end else begin
            audioSync1 <= audioClk;
            audioSync2 <= audioSync1;
            audioSync3 <= audioSync2;
        end
    end

    // FSM state register.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next state: issue every voice, wait for all tags to return, publish once.
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (strobe) nextState = S_ISSUE;
            S_ISSUE: if (lastVoice) nextState = S_DRAIN;
            S_DRAIN: if (tagCount == '0) nextState = S_DONE;
            S_DONE:  nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    // FSM outputs: the core sees a phase only for enabled voices.
    always_comb begin
        cordic_tvalid = issueNow;
        cordic_tdata  = issueNow ? nextPhase : '0;
        sample_valid  = (state == S_DONE);
    end

    // Shadow inputs at the strobe, then step the voice index and accumulators.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            voiceIdx <= '0;
            enShadow <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                incShadow[v] <= '0;
                phaseAcc[v]  <= PHASE_RESET;
            end
        end else begin
            if ((state == S_IDLE) && strobe) begin
                voiceIdx <= '0;
                enShadow <= voice_en;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    incShadow[v] <= phase_inc[v*PHASE_W +: PHASE_W];
                end
            end
            if (state == S_ISSUE) begin
                if (issueNow) begin
                    phaseAcc[voiceIdx] <= nextPhase;
                end
                if (!lastVoice) begin
                    voiceIdx <= voiceIdx + TAG_W'(1);
                end
            end
        end
    end

    // Collect results by tag; disabled voices contribute silence.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                sampleShadow[v] <= '0;
            end
        end else begin
            if ((state == S_ISSUE) && !enShadow[voiceIdx]) begin
                sampleShadow[voiceIdx] <= '0;
            end
            if (cordic_rvalid && !tagEmpty) begin
                sampleShadow[tagOut] <= cordic_rdata[15:0];
            end
        end
    end

    // Publish all voices at once so the mixer never sees a half-updated set.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            voice_sin <= '0;
        end else if ((state == S_DRAIN) && (nextState == S_DONE)) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_sin[v*PHASE_W +: PHASE_W] <= sampleShadow[v];
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge sysClk or negedge nReset) begin
        if (!nReset) begin
            overrun      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (strobe && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
            if (cordic_rvalid && tagEmpty) begin
                protocol_err <= 1'b1;
            end else if (clear_flags) begin
                protocol_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_voice_scheduler.sv
// tb/tb_cordic_voice_scheduler.sv - scoreboard bench with a fixed-latency sine core model
module tb_cordic_voice_scheduler;

    localparam int NV   = 4;
    localparam int LAT  = 20;
    localparam int PI_I = 25736;

    logic            sysClk = 1'b0;
    logic            nReset;
    logic            audioClk;
    logic [NV*16-1:0] phase_inc;
    logic [NV-1:0]   voice_en;
    logic            clear_flags;
    logic            cordic_tvalid;
    logic [15:0]     cordic_tdata;
    logic            cordic_rvalid;
    logic [31:0]     cordic_rdata;
    logic [NV*16-1:0] voice_sin;
    logic            sample_valid;
    logic            overrun;
    logic            protocol_err;

    always #5 sysClk = ~sysClk;

    cordic_voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(16)) dut (
        .sysClk        (sysClk),
        .nReset        (nReset),
        .audioClk      (audioClk),
        .phase_inc     (phase_inc),
        .voice_en      (voice_en),
        .clear_flags   (clear_flags),
        .cordic_tvalid (cordic_tvalid),
        .cordic_tdata  (cordic_tdata),
        .cordic_rvalid (cordic_rvalid),
        .cordic_rdata  (cordic_rdata),
        .voice_sin     (voice_sin),
        .sample_valid  (sample_valid),
        .overrun       (overrun),
        .protocol_err  (protocol_err)
    );

    int nVec = 0;
    int nMis = 0;
    int svCount = 0;
    int modelAcc [NV];
    logic [15:0] expIssue [$];
    logic [63:0] expSample [$];
    logic [15:0] issuedLog [$];
    logic [63:0] lastPub;
    logic [63:0] popped;
    bit          injectSpurious = 0;
    logic        pipeV [0:LAT];
    logic [15:0] pipeD [0:LAT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int wrapRef(input int acc, input int inc);
        int s;
        s = acc + ((inc > PI_I) ? PI_I : inc);
        if (s > PI_I) s = s - 2 * PI_I;
        return s;
    endfunction

    function automatic logic [15:0] sinRef(input logic [15:0] ph);
        int  p;
        int  q;
        real r;
        p = $signed(ph);
        r = $sin($itor(p) / 8192.0) * 16384.0;
        q = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        return q[15:0];
    endfunction

    function automatic logic [15:0] randInc();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 16'h0800));
            1:       return 16'($urandom_range(0, PI_I));
            2:       return 16'($urandom);
            default: return 16'h6488;
        endcase
    endfunction

    task automatic modelReset();
        for (int v = 0; v < NV; v++) modelAcc[v] = -8192;
        expIssue.delete();
        expSample.delete();
        lastPub = '0;
    endtask

    task automatic predictStrobe();
        logic [63:0] s;
        s = '0;
        for (int v = 0; v < NV; v++) begin
            if (voice_en[v]) begin
                modelAcc[v] = wrapRef(modelAcc[v], int'(phase_inc[16*v +: 16]));
                expIssue.push_back(16'(modelAcc[v]));
                s[16*v +: 16] = sinRef(16'(modelAcc[v]));
            end
        end
        expSample.push_back(s);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysClk);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (expSample.size() != 0 && n < 200) begin
            @(negedge sysClk);
            n++;
        end
        check(name, 64'(expSample.size()), 64'd0);
    endtask

    task automatic doStrobe(input logic [NV-1:0] en, input logic [NV*16-1:0] inc);
        voice_en  = en;
        phase_inc = inc;
        predictStrobe();
        audioClk = 1'b1;
        waitDone("strobe_done");
        audioClk = 1'b0;
        tick(4);
    endtask

    task automatic pulseClear();
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        tick(1);
    endtask

    task automatic applyReset();
        nReset = 1'b0;
        tick(2);
        modelReset();
        nReset = 1'b1;
        tick(3);
    endtask

    // Fixed-latency core model: sine of the issued phase returns LAT cycles later.
    initial begin
        cordic_rvalid = 1'b0;
        cordic_rdata  = '0;
        for (int i = 0; i <= LAT; i++) begin
            pipeV[i] = 1'b0;
            pipeD[i] = '0;
        end
        forever begin
            @(negedge sysClk);
            for (int i = LAT; i > 0; i--) begin
                pipeV[i] = pipeV[i-1];
                pipeD[i] = pipeD[i-1];
            end
            pipeV[0] = cordic_tvalid;
            pipeD[0] = cordic_tdata;
            if (injectSpurious) begin
                cordic_rvalid  = 1'b1;
                cordic_rdata   = $urandom;
                injectSpurious = 0;
            end else begin
                cordic_rvalid = pipeV[LAT];
                cordic_rdata  = {16'($urandom), pipeV[LAT] ? sinRef(pipeD[LAT]) : 16'h0000};
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues a phase or publishes samples.
    initial begin
        forever begin
            @(negedge sysClk);
            if (cordic_tvalid === 1'b1) begin
                issuedLog.push_back(cordic_tdata);
                if (expIssue.size() == 0) check("unexpected_issue", 64'd1, 64'd0);
                else check("issue_tdata", 64'(cordic_tdata), 64'(expIssue.pop_front()));
            end
            if (sample_valid === 1'b1) begin
                svCount++;
                if (expSample.size() == 0) begin
                    check("unexpected_sample", 64'd1, 64'd0);
                end else begin
                    popped = expSample.pop_front();
                    check("voice_sin", voice_sin, popped);
                    lastPub = popped;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t1Exp [5];
        int n, tFirst, run, tSv, sv0;
        t1Exp = '{16'hE7FF, 16'hEFFE, 16'hF7FD, 16'hFFFC, 16'h07FB};

        nReset = 1'b0;
        audioClk = 1'b0;
        clear_flags = 1'b0;
        voice_en = '0;
        phase_inc = '0;
        modelReset();
        tick(3);
        check("reset_tvalid", 64'(cordic_tvalid), 64'd0);
        check("reset_tdata", 64'(cordic_tdata), 64'd0);
        check("reset_voice_sin", voice_sin, 64'd0);
        check("reset_sample_valid", 64'(sample_valid), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        check("reset_protocol_err", 64'(protocol_err), 64'd0);
        nReset = 1'b1;
        tick(3);

        // Single voice stepping from -1.0.
        issuedLog.delete();
        svCount = 0;
        repeat (5) doStrobe(4'b0001, {16'h0, 16'h0, 16'h0, 16'h07FF});
        check("t1_issue_count", 64'(issuedLog.size()), 64'd5);
        for (int i = 0; i < 5; i++) check("t1_tdata", 64'(issuedLog[i]), 64'(t1Exp[i]));
        check("t1_sample_count", 64'(svCount), 64'd5);
        check("t1_upper_voices_zero", 64'(voice_sin[63:16]), 64'd0);

        // Wrap past +pi.
        applyReset();
        repeat (4) doStrobe(4'b0001, {48'h0, 16'h2000});
        issuedLog.delete();
        repeat (2) doStrobe(4'b0001, {48'h0, 16'h1000});
        check("t2_wrap_phase", 64'(issuedLog[0]), 64'h0000_0000_0000_A6F0);
        check("t2_next_phase", 64'(issuedLog[1]), 64'h0000_0000_0000_B6F0);

        // All voices: back-to-back issue and strobe-to-publish latency.
        voice_en  = 4'b1111;
        phase_inc = {16'h2ABC, 16'h1789, 16'h0456, 16'h0123};
        predictStrobe();
        audioClk = 1'b1;
        n = 0; tFirst = -1; run = 0; tSv = -1;
        while (n < 200 && tSv < 0) begin
            @(negedge sysClk);
            n++;
            if (cordic_tvalid === 1'b1) begin
                if (tFirst < 0) tFirst = n;
                if (n == tFirst + run) run++;
            end
            if (sample_valid === 1'b1) tSv = n;
        end
        check("t3_issue_run", 64'(run), 64'd4);
        check("t3_latency", 64'(tSv - tFirst + 1), 64'(NV + LAT + 2));
        waitDone("t3_done");
        audioClk = 1'b0;
        tick(4);

        // Strobe while busy: flagged, ignored, single publish.
        voice_en  = 4'b1111;
        for (int v = 0; v < NV; v++) phase_inc[16*v +: 16] = randInc();
        predictStrobe();
        sv0 = svCount;
        audioClk = 1'b1;
        tick(4);
        audioClk = 1'b0;
        tick(6);
        audioClk = 1'b1;
        waitDone("t4_done");
        tick(40);
        check("t4_overrun_set", 64'(overrun), 64'd1);
        check("t4_single_sample", 64'(svCount - sv0), 64'd1);
        audioClk = 1'b0;
        tick(4);
        pulseClear();
        check("t4_overrun_cleared", 64'(overrun), 64'd0);

        // Spurious result in IDLE.
        injectSpurious = 1;
        tick(3);
        check("t5_protocol_err", 64'(protocol_err), 64'd1);
        check("t5_voice_sin_held", voice_sin, lastPub);
        pulseClear();
        check("t5_protocol_err_cleared", 64'(protocol_err), 64'd0);

        // Reset during DRAIN.
        voice_en  = 4'b1111;
        for (int v = 0; v < NV; v++) phase_inc[16*v +: 16] = randInc();
        predictStrobe();
        audioClk = 1'b1;
        n = 0;
        while (n < 50 && cordic_tvalid !== 1'b1) begin
            @(negedge sysClk);
            n++;
        end
        check("t6_issue_seen", 64'(cordic_tvalid), 64'd1);
        tick(10);
        nReset = 1'b0;
        #1;
        check("t6_rst_tvalid", 64'(cordic_tvalid), 64'd0);
        check("t6_rst_sample_valid", 64'(sample_valid), 64'd0);
        check("t6_rst_voice_sin", voice_sin, 64'd0);
        check("t6_rst_overrun", 64'(overrun), 64'd0);
        modelReset();
        audioClk = 1'b0;
        tick(2);
        nReset = 1'b1;
        tick(30);
        check("t6_late_result_err", 64'(protocol_err), 64'd1);
        pulseClear();
        doStrobe(4'b1111, {16'h0400, 16'h0300, 16'h0200, 16'h0100});
        check("t6_clean_protocol_err", 64'(protocol_err), 64'd0);
        check("t6_clean_overrun", 64'(overrun), 64'd0);

        // All voices disabled publishes silence.
        doStrobe(4'b0000, {16'h1111, 16'h2222, 16'h3333, 16'h4444});
        check("all_disabled_zero", voice_sin, 64'd0);

        // Randomised enables and increments, including clamp and exact-pi cases.
        repeat (14) begin
            logic [NV*16-1:0] inc;
            for (int v = 0; v < NV; v++) inc[16*v +: 16] = randInc();
            doStrobe(4'($urandom_range(0, 15)), inc);
        end
        doStrobe(4'b1111, {4{16'hFFFF}});

        tick(5);
        check("final_issue_queue_empty", 64'(expIssue.size()), 64'd0);
        check("final_overrun", 64'(overrun), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
